led_blinker_bank: RTL



---
 rtl/led_pkg.sv | 17 +
 rtl/led_blinker_bank_if.sv | 20 ++
 rtl/led_blinker_bank_channel.sv | 84 ++++++++
 rtl/led_blinker_bank.sv | 64 ++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blinker bank.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PULSE = 2'd3
    } led_mode_t;

    // A programmed half-period of zero behaves as one tick, so the
    // channel counter can never stall or wrap.
    function automatic int unsigned eff_half(input int unsigned half);
        return (half == 0) ? 1 : half;
    endfunction

endpackage

// File: rtl/led_blinker_bank_if.sv
// Configuration port of the LED blinker bank: write strobe, target channel,
// mode/half-period payload and the global phase resync.
interface led_blinker_bank_if #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned CNT_W = 16
);
    import led_pkg::*;

    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    led_mode_t        cfg_mode;
    logic [CNT_W-1:0] cfg_half;
    logic             sync;

    modport master (output cfg_we, cfg_ch, cfg_mode, cfg_half, sync);
    modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_half, sync);

endinterface

// File: rtl/led_blinker_bank_channel.sv
// One LED channel: tick counter, phase bit, stored mode/half-period and the
// registered LED drive derived from the next-state values.
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEFAULT_HALF = 500,
    parameter led_mode_t   DEFAULT_MODE = LED_BLINK
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             tick,
    input  logic             wr,
    input  led_mode_t        wr_mode,
    input  logic [CNT_W-1:0] wr_half,
    input  logic             sync,
    output logic             led
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_nxt;
    logic [CNT_W-1:0] last;
    logic             ph;
    logic             ph_nxt;
    led_mode_t        mode;
    led_mode_t        mode_nxt;
    logic             led_nxt;

    // Next state: a write or sync restarts the phase and swallows a coincident tick.
    always_comb begin
        mode_nxt = mode;
        half_nxt = half;
        cnt_nxt  = cnt;
        ph_nxt   = ph;
        last     = CNT_W'(eff_half(32'(half)) - 1);
        if (wr) begin
            mode_nxt = wr_mode;
            half_nxt = wr_half;
        end
        if (wr || sync) begin
            cnt_nxt = '0;
            ph_nxt  = 1'b0;
        end else if (tick) begin
            if (cnt == last) begin
                cnt_nxt = '0;
                ph_nxt  = ~ph;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // LED drive from next-state so it lands on the same edge as cnt/ph.
    always_comb begin
        led_nxt = 1'b0;
        case (mode_nxt)
            LED_OFF:   led_nxt = 1'b0;
            LED_ON:    led_nxt = 1'b1;
            LED_BLINK: led_nxt = ph_nxt;
            LED_PULSE: led_nxt = ph_nxt && (cnt_nxt == '0);
            default:   led_nxt = 1'b0;
        endcase
    end

    // Channel state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt  <= '0;
            ph   <= 1'b0;
            mode <= DEFAULT_MODE;
            half <= CNT_W'(DEFAULT_HALF);
            led  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            ph   <= ph_nxt;
            mode <= mode_nxt;
            half <= half_nxt;
            led  <= led_nxt;
        end
    end

endmodule

// File: rtl/led_blinker_bank.sv
// Bank of NCH independent LED drivers sharing one base-tick prescaler.
module led_blinker_bank
    import led_pkg::*;
#(
    parameter int unsigned NCH          = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PRESCALE     = 100000,
    parameter int unsigned DEFAULT_HALF = 500,
    parameter int unsigned DEFAULT_MODE = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    led_blinker_bank_if.slave  cfg,
    output logic               tick,
    output logic [NCH-1:0]     led
);

    localparam int unsigned PS_W     = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam led_mode_t   DEF_MODE = led_mode_t'(2'(DEFAULT_MODE));

    logic [PS_W-1:0] presc;
    logic [NCH-1:0]  wr_sel;

    // Prescaler: sync restarts the count and suppresses the tick for that cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (cfg.sync) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (presc == PS_LAST);
            presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
        end
    end

    // Write decode: an index at or above NCH matches no channel and is dropped.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr_sel[i] = cfg.cfg_we && (32'(cfg.cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF),
            .DEFAULT_MODE (DEF_MODE)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .tick      (tick),
            .wr        (wr_sel[g]),
            .wr_mode   (cfg.cfg_mode),
            .wr_half   (cfg.cfg_half),
            .sync      (cfg.sync),
            .led       (led[g])
        );
    end

endmodule
